// File: rtl/reduce_gates_accum.sv
// AND/OR/XOR reduction of input words, either one result per word (word mode)
// or one result per in_last-terminated frame (frame mode), behind a valid/ready pair.
module reduce_gates_accum #(
  parameter int NBITS = 4,
  parameter int CBITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [NBITS-1:0] in_msg,
  input  logic             in_last,
  input  logic             in_val,
  output logic             in_rdy,
  output logic             out_and,
  output logic             out_nand,
  output logic             out_or,
  output logic             out_nor,
  output logic             out_xor,
  output logic [CBITS-1:0] out_cnt,
  output logic             out_val,
  input  logic             out_rdy
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CBITS-1:0] CNT_MAX = '1;

  state_t           state;
  logic             acc_and;
  logic             acc_or;
  logic             acc_xor;
  logic [CBITS-1:0] acc_cnt;

  logic             in_xfer;
  logic             out_xfer;
  logic             frame_mode;
  logic             produce;
  logic             accumulate;
  logic             nxt_and;
  logic             nxt_or;
  logic             nxt_xor;
  logic [CBITS-1:0] nxt_cnt;

  assign in_rdy   = !out_val || out_rdy;
  assign in_xfer  = in_val && in_rdy;
  assign out_xfer = out_val && out_rdy;
  assign out_nand = ~out_and;
  assign out_nor  = ~out_or;

  // ACCUM is only ever entered in frame mode, so the state itself holds the
  // frame's mode and the live mode input only matters in IDLE.
  assign frame_mode = (state == ACCUM) || mode;
  assign produce    = in_xfer && (!frame_mode || in_last);
  assign accumulate = in_xfer && frame_mode && !in_last;

  // Value of the accumulators once the current word is folded in.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    nxt_and = &in_msg;
    nxt_or  = |in_msg;
    nxt_xor = ^in_msg;
    nxt_cnt = CBITS'(1);
    if (state == ACCUM) begin
      nxt_and = acc_and & (&in_msg);
      nxt_or  = acc_or | (|in_msg);
      nxt_xor = acc_xor ^ (^in_msg);
      nxt_cnt = (acc_cnt == CNT_MAX) ? acc_cnt : acc_cnt + CBITS'(1);
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      acc_and <= 1'b0;
      acc_or  <= 1'b0;
      acc_xor <= 1'b0;
      acc_cnt <= '0;
      out_and <= 1'b0;
      out_or  <= 1'b0;
      out_xor <= 1'b0;
      out_cnt <= '0;
      out_val <= 1'b0;
    end else begin
      if (produce) begin
        out_and <= nxt_and;
        out_or  <= nxt_or;
        out_xor <= nxt_xor;
        out_cnt <= nxt_cnt;
        out_val <= 1'b1;
        state   <= IDLE;
      end else if (out_xfer) begin
        out_val <= 1'b0;
      end

      if (accumulate) begin
        acc_and <= nxt_and;
        acc_or  <= nxt_or;
        acc_xor <= nxt_xor;
        acc_cnt <= nxt_cnt;
        state   <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_reduce_gates_accum.sv
// Self-checking bench for reduce_gates_accum: queue-based frame model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_reduce_gates_accum;

  localparam int NBITS = 4;
  localparam int CBITS = 4;
  localparam int CMAX  = (1 << CBITS) - 1;

  logic             clk;
  logic             reset;
  logic             mode;
  logic [NBITS-1:0] in_msg;
  logic             in_last;
  logic             in_val;
  logic             in_rdy;
  logic             out_and, out_nand, out_or, out_nor, out_xor;
  logic [CBITS-1:0] out_cnt;
  logic             out_val;
  logic             out_rdy;

  int n_cmp = 0;
  int n_err = 0;

  reduce_gates_accum #(.NBITS(NBITS), .CBITS(CBITS)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_msg(in_msg), .in_last(in_last),
    .in_val(in_val), .in_rdy(in_rdy), .out_and(out_and), .out_nand(out_nand),
    .out_or(out_or), .out_nor(out_nor), .out_xor(out_xor), .out_cnt(out_cnt),
    .out_val(out_val), .out_rdy(out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect the words of the current frame, reduce them all
  // when the frame (or single word) completes.
  logic [NBITS-1:0] words[$];
  bit m_in_frame, m_fmode, m_val, m_and, m_or, m_xor, m_rdy, m_fm, m_done;
  int m_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      words.delete();
      m_in_frame = 0; m_fmode = 0; m_val = 0;
      m_and = 0; m_or = 0; m_xor = 0; m_cnt = 0;
    end else begin
      m_rdy  = !m_val || out_rdy;
      m_done = 0;
      if (in_val && m_rdy) begin
        m_fm = m_in_frame ? m_fmode : mode;
        words.push_back(in_msg);
        if (!m_fm || in_last) begin
          m_and = 1; m_or = 0; m_xor = 0;
          foreach (words[i]) begin
            m_and = m_and & (&words[i]);
            m_or  = m_or | (|words[i]);
            m_xor = m_xor ^ (^words[i]);
          end
          m_cnt = (words.size() > CMAX) ? CMAX : words.size();
          words.delete();
          m_in_frame = 0;
          m_done = 1;
        end else begin
          m_in_frame = 1;
          m_fmode = m_fm;
        end
      end
      if (m_done) m_val = 1;
      else if (m_val && out_rdy) m_val = 0;
    end
  end

  always @(negedge clk) begin
    check("out_val", out_val, m_val);
    check("out_and", out_and, m_and);
    check("out_nand", out_nand, !m_and);
    check("out_or", out_or, m_or);
    check("out_nor", out_nor, !m_or);
    check("out_xor", out_xor, m_xor);
    check("out_cnt", out_cnt, m_cnt);
    check("in_rdy", in_rdy, !m_val || out_rdy);
  end

  // Inputs change 1 time unit after the falling edge; returns at the same
  // point one cycle later, with the rising edge applied.
  task automatic drive(input bit v, input bit m, input logic [NBITS-1:0] msg,
                       input bit last, input bit ordy);
    in_val = v; mode = m; in_msg = msg; in_last = last; out_rdy = ordy;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; mode = 0; in_msg = '0; in_last = 0; in_val = 0; out_rdy = 1;
    #3;
    check("rst_val", out_val, 0);
    check("rst_cnt", out_cnt, 0);
    check("rst_nand", out_nand, 1);
    check("rst_nor", out_nor, 1);
    check("rst_in_rdy", in_rdy, 1);
    @(negedge clk); #1;
    reset = 1'b1;

    // Word-mode sweep; in_last is random and must be ignored.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'(i), 1'($urandom), 1'b1);
    check("sweep_and", out_and, 1);
    check("sweep_nand", out_nand, 0);
    check("sweep_or", out_or, 1);
    check("sweep_nor", out_nor, 0);
    check("sweep_xor", out_xor, 0);
    check("sweep_cnt", out_cnt, 1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Three-word frame.
    drive(1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
    check("frm_val1", out_val, 0);
    drive(1'b1, 1'b1, 4'b1011, 1'b0, 1'b1);
    check("frm_val2", out_val, 0);
    drive(1'b1, 1'b1, 4'b0001, 1'b1, 1'b1);
    check("frm_val", out_val, 1);
    check("frm_and", out_and, 0);
    check("frm_or", out_or, 1);
    check("frm_xor", out_xor, 0);
    check("frm_cnt", out_cnt, 3);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Counter saturation over a 20-word frame.
    for (int i = 0; i < 19; i++) drive(1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1);
    check("sat_cnt", out_cnt, 15);
    check("sat_and", out_and, 1);
    check("sat_xor", out_xor, 0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Backpressure: pending result held while the consumer stalls.
    drive(1'b1, 1'b0, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'b0110, 1'b0, 1'b0);
      check("bp_in_rdy", in_rdy, 0);
      check("bp_hold_and", out_and, 1);
      check("bp_hold_val", out_val, 1);
    end
    drive(1'b1, 1'b0, 4'b0110, 1'b0, 1'b1);
    check("bp_new_val", out_val, 1);
    check("bp_new_and", out_and, 0);
    check("bp_new_or", out_or, 1);
    check("bp_new_xor", out_xor, 0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Reset mid-frame discards the partial frame.
    drive(1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_cnt", out_cnt, 0);
    reset = 1'b1;
    drive(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1);
    check("post_rst_and", out_and, 1);
    check("post_rst_or", out_or, 1);
    check("post_rst_cnt", out_cnt, 1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Mode dropped mid-frame: the frame still runs to in_last.
    drive(1'b1, 1'b1, 4'b1100, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 4'b1010, 1'b0, 1'b1);
    check("mt_val", out_val, 0);
    drive(1'b1, 1'b0, 4'b0111, 1'b1, 1'b1);
    check("mt_val_end", out_val, 1);
    check("mt_and", out_and, 0);
    check("mt_or", out_or, 1);
    check("mt_xor", out_xor, 1);
    check("mt_cnt", out_cnt, 3);

    // Random traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
      drive(($urandom_range(0, 9) < 7), 1'($urandom), 4'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reduce_gates_accum.md
REDUCE_GATES_ACCUM -- requirements
Module: reduce_gates_accum

Interface
REQ-001: Parameter NBITS SHALL be: NBITS, default 4, width of each input word to reduce (>=1).
REQ-002: Parameter CBITS SHALL be: CBITS, default 4, width of the word counter (>=1).
REQ-003: Port clk SHALL be: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: Port reset SHALL be: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005: Port mode SHALL be: mode  input  1  0 = word mode, 1 = frame mode.
REQ-006: Port in_msg SHALL be: in_msg  input  NBITS  input word.
REQ-007: Port in_last SHALL be: in_last  input  1  marks final word of a frame (frame mode only).
REQ-008: Port in_val SHALL be: in_val  input  1  input valid.
REQ-009: Port in_rdy SHALL be: in_rdy  output  1  input ready.
REQ-010: Ports out_and, out_nand, out_or, out_nor, out_xor SHALL each be: output  1  reduction results.
REQ-011: Port out_cnt SHALL be: out_cnt  output  CBITS  number of words reduced into the current result.
REQ-012: Port out_val SHALL be: out_val  output  1  result valid.
REQ-013: Port out_rdy SHALL be: out_rdy  input  1  consumer ready.

Function
REQ-014: An input transfer SHALL occur on a rising edge where in_val && in_rdy; an output transfer where out_val && out_rdy.
REQ-015: in_rdy SHALL be combinational: !out_val || out_rdy; no other term.
REQ-016: Word mode: every input transfer SHALL load the result registers with &in_msg, |in_msg, ^in_msg, set out_cnt=1 and out_val=1 on the same edge (latency 1 cycle).
REQ-017: out_nand SHALL equal ~out_and and out_nor SHALL equal ~out_or at all times.
REQ-018: FSM states SHALL be IDLE and ACCUM; mode SHALL be sampled only on a transfer in IDLE and held for the whole frame.
REQ-019: Frame mode, IDLE, transfer with in_last=0: initialise accumulators from the word (and, or, xor, cnt=1), go to ACCUM, out_val unchanged by accumulation.
REQ-020: ACCUM, transfer with in_last=0: acc_and &= &in_msg, acc_or |= |in_msg, acc_xor ^= ^in_msg, cnt += 1.
REQ-021: Frame-mode transfer with in_last=1 (IDLE or ACCUM): result registers SHALL load accumulators combined with that word, out_val=1, state -> IDLE.
REQ-022: cnt SHALL saturate at 2^CBITS-1 and never wrap.
REQ-023: While out_val && !out_rdy, all result outputs SHALL hold stable.
REQ-024: Output transfer with no result-producing input transfer on the same edge SHALL clear out_val; result data bits hold.
REQ-025: Simultaneous output transfer and result-producing input transfer SHALL load the new result and keep out_val=1, with no bubble.
REQ-026: mode changes while in ACCUM SHALL be ignored until the frame ends.
REQ-027: in_last SHALL be ignored in word mode.
REQ-028: NBITS=1 SHALL yield out_and = out_or = out_xor = in_msg for word-mode transfers.

Reset
REQ-029: reset=0 SHALL immediately, without a clock edge, set state=IDLE, clear all accumulators, out_val=0, out_and=0, out_or=0, out_xor=0, out_cnt=0 (hence out_nand=1, out_nor=1, in_rdy=1).
REQ-030: Reset asserted mid-frame SHALL discard the partial frame; the next transfer after release SHALL start a new frame.
REQ-031: First transfer SHALL be possible on the first rising edge after reset returns to 1.

Verification
REQ-032: Word mode, NBITS=4, out_rdy=1, sweep in_msg 0000..1111 one per cycle -> each next cycle matches &,~&,|,~|,^ of the word with out_cnt=1; e.g. 1111 -> and=1 nand=0 or=1 nor=0 xor=0.
REQ-033: Frame mode, words 1111, 1011, 0001(last) -> one cycle after last: out_val=1, and=0, or=1, xor=0, cnt=3; out_val=0 during the first two words.
REQ-034: Backpressure: result pending, out_rdy=0 for 3 cycles with in_val=1 -> in_rdy=0, outputs stable; out_rdy=1 -> old result accepted and new one loaded on the same edge, out_val stays 1.
REQ-035: Saturation: CBITS=4, frame of 20 words of 1111 -> out_cnt=15, and=1, xor=0.
REQ-036: Reset=0 after 2 frame words, release, single word 1111 with in_last=1 -> and=1, or=1, cnt=1.
REQ-037: Mode toggled 1->0 mid-frame -> frame still completes on in_last with correct accumulated values.
